// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic PE array: skews A columns / B rows onto the array edges
// and sequences clear -> feed -> flush -> done. Optional k_count: define FEEDER_KCOUNT_EN.
module systolic_feeder #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 10,
   parameter int KW         = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic [N*DATA_WIDTH-1:0] in_a,
   input  logic [N*DATA_WIDTH-1:0] in_b,
   output logic [N*DATA_WIDTH-1:0] a_edge,
   output logic [N*DATA_WIDTH-1:0] b_edge,
   output logic                    arr_clr,
   output logic                    busy,
   output logic                    done,
   output logic [KW-1:0]           k_count
);

   localparam int             CW         = $clog2(2 * N);
   localparam logic [CW-1:0]  FLUSH_LAST = CW'(2 * N - 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   flush_q, flush_d;
   logic            arr_clr_q, in_ready_q, busy_q, done_q;
   logic            accept;

   assign accept   = in_valid & in_ready_q;
   assign in_ready = in_ready_q;
   assign arr_clr  = arr_clr_q;
   assign busy     = busy_q;
   assign done     = done_q;

   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_FEED;
         S_FEED: begin
            if (accept && in_last) begin
               state_d = S_FLUSH;
               flush_d = FLUSH_LAST;
            end
         end
         // Counts the 2N edges after the last accept so done lands on edge T+2N.
         S_FLUSH: begin
            if (flush_q == '0) state_d = S_DONE;
            else               flush_d = flush_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control outputs are registered from the next state so they align with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         flush_q    <= '0;
         arr_clr_q  <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_q    <= flush_d;
         arr_clr_q  <= (state_d == S_CLEAR);
         in_ready_q <= (state_d == S_FEED);
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
      end
   end

`ifdef FEEDER_KCOUNT_EN
   function automatic logic [KW-1:0] sat_inc(input logic [KW-1:0] v);
      return (v == {KW{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic [KW-1:0] k_q, k_d;

   always_comb begin
      k_d = k_q;
      if (state_q == S_IDLE && start) k_d = '0;
      else if (accept)                k_d = sat_inc(k_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) k_q <= '0;
      else     k_q <= k_d;
   end

   assign k_count = k_q;
`else
   assign k_count = '0;
`endif

   // Lane i is i+1 deep; non-accept cycles shift in zero bubbles on every lane together.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] a_sr_q [i+1];
      logic signed [DATA_WIDTH-1:0] b_sr_q [i+1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s <= i; s++) begin
               a_sr_q[s] <= '0;
               b_sr_q[s] <= '0;
            end
         end else begin
            a_sr_q[0] <= accept ? in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            b_sr_q[0] <= accept ? in_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int s = 1; s <= i; s++) begin
               a_sr_q[s] <= a_sr_q[s-1];
               b_sr_q[s] <= b_sr_q[s-1];
            end
         end
      end

      assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = a_sr_q[i];
      assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = b_sr_q[i];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: timeline reference model plus a behavioural PE-array product check.
module tb_systolic_feeder;
   localparam int N   = 4;
   localparam int DW  = 10;
   localparam int KW  = 8;
   localparam int NDW = N * DW;
   localparam int EW  = 4 + KW + 2 * NDW;
   localparam int HD  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic [NDW-1:0] in_a = '0, in_b = '0;
   logic           in_ready, arr_clr, busy, done;
   logic [NDW-1:0] a_edge, b_edge;
   logic [KW-1:0]  k_count;

   systolic_feeder #(.N(N), .DATA_WIDTH(DW), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_a(in_a), .in_b(in_b), .a_edge(a_edge), .b_edge(b_edge),
      .arr_clr(arr_clr), .busy(busy), .done(done), .k_count(k_count)
   );

   int checks = 0, failures = 0;

   // Reference model: edge index, operation timeline, and what each edge accepted.
   int             m_e = 0, t_start = -1000, t_last = -1000, m_k = 0;
   bit             m_active = 1'b0, m_have_last = 1'b0;
   logic [NDW-1:0] hist_a [HD], hist_b [HD], obs_a [HD], obs_b [HD];
   logic [NDW-1:0] q_a [$], q_b [$];

   wire [EW-1:0] obs_v = {arr_clr, in_ready, busy, done, k_count, a_edge, b_edge};

   function automatic int hidx(input int t);
      return ((t % HD) + HD) % HD;
   endfunction

   function automatic logic [EW-1:0] exp_v();
      logic [NDW-1:0] ea, eb;
      logic [KW-1:0]  ek;
      for (int i = 0; i < N; i++) begin
         ea[i*DW +: DW] = hist_a[hidx(m_e - i)][i*DW +: DW];
         eb[i*DW +: DW] = hist_b[hidx(m_e - i)][i*DW +: DW];
      end
`ifdef FEEDER_KCOUNT_EN
      ek = KW'(m_k);
`else
      ek = '0;
`endif
      return {m_active && (m_e == t_start),
              m_active && !m_have_last && (m_e >= t_start + 1),
              m_active,
              m_active && m_have_last && (m_e == t_last + 2 * N),
              ek, ea, eb};
   endfunction

   function automatic logic [NDW-1:0] rnd_vec();
      logic [NDW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   task automatic gen(input int mode, input int ka, output logic [NDW-1:0] va, output logic [NDW-1:0] vb);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: begin
               va[i*DW +: DW] = (i == ka) ? DW'(1) : '0;
               vb[i*DW +: DW] = (i == ka) ? DW'(1) : '0;
            end
            1: begin
               va[i*DW +: DW] = DW'($urandom);
               vb[i*DW +: DW] = DW'($urandom);
            end
            2: begin
               va[i*DW +: DW] = DW'(-3);
               vb[i*DW +: DW] = DW'(5);
            end
            default: begin
               va[i*DW +: DW] = DW'(i + 1);
               vb[i*DW +: DW] = DW'(-(10 * (i + 1)));
            end
         endcase
      end
   endtask

   // Advance one clock: update the model from the inputs seen at the edge, then record outputs mid-cycle.
   task automatic tick();
      logic acc;
      acc = 1'b0;
      @(posedge clk);
      m_e++;
      if (rst) begin
         m_active = 1'b0; m_have_last = 1'b0; m_k = 0;
         for (int t = 0; t < HD; t++) begin
            hist_a[t] = '0; hist_b[t] = '0;
         end
      end else begin
         if (!m_active) begin
            if (start) begin
               m_active = 1'b1; m_have_last = 1'b0; t_start = m_e; m_k = 0;
               q_a.delete(); q_b.delete();
            end
         end else begin
            acc = !m_have_last && (m_e >= t_start + 2) && in_valid;
            if (acc) begin
               q_a.push_back(in_a); q_b.push_back(in_b);
               if (m_k < (1 << KW) - 1) m_k++;
               if (in_last) begin m_have_last = 1'b1; t_last = m_e; end
            end else if (m_have_last && m_e == t_last + 2 * N + 1) begin
               m_active = 1'b0;
            end
         end
         hist_a[hidx(m_e)] = acc ? in_a : '0;
         hist_b[hidx(m_e)] = acc ? in_b : '0;
      end
      @(negedge clk);
      obs_a[hidx(m_e)] = a_edge;
      obs_b[hidx(m_e)] = b_edge;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL reset_state e=%0d got=%h want=%h", m_e, obs_v, exp_v());
         end
      end
      rst = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) start = 1'b0;
         if (c == 2) begin in_valid = 1'b1; in_a = rnd_vec(); in_b = rnd_vec(); end
         if (c == 5) rst = 1'b1;
         tick();
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL reset_mid_run e=%0d got=%h want=%h", m_e, obs_v, exp_v());
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      checks++;
      if (obs_v !== exp_v()) begin
         failures++; $display("FAIL reset_release e=%0d got=%h want=%h", m_e, obs_v, exp_v());
      end
   endtask

   task automatic test_feed(input string name, input int mode, input int K, input int bub);
      logic [NDW-1:0] va, vb;
      int guard, ka, got, want;
      start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      tick();
      checks++;
      if (obs_v !== exp_v()) begin
         failures++; $display("FAIL %s_start e=%0d got=%h want=%h", name, m_e, obs_v, exp_v());
      end
      start = 1'b0;
      guard = 0;
      while (!m_have_last && guard < 300) begin
         ka = q_a.size();
         gen(mode, ka, va, vb);
         in_a = va; in_b = vb;
         in_valid = (int'($urandom_range(99)) >= bub);
         in_last  = (ka == K - 1);
         tick();
         guard++;
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL %s_feed e=%0d got=%h want=%h", name, m_e, obs_v, exp_v());
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (guard >= 300) begin
         checks++; failures++; $display("FAIL %s_feed_timeout beats=%0d want=%0d", name, q_a.size(), K);
      end
      guard = 0;
      while (m_active && guard < 4 * N + 4) begin
         tick();
         guard++;
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL %s_flush e=%0d got=%h want=%h", name, m_e, obs_v, exp_v());
         end
         if (m_active && m_have_last && m_e == t_last + 2 * N) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  want = 0;
                  foreach (q_a[k]) want += $signed(q_a[k][i*DW +: DW]) * $signed(q_b[k][j*DW +: DW]);
                  got = 0;
                  for (int t = t_start; t <= m_e; t++) begin
                     if (t - j >= t_start && t - i >= t_start)
                        got += $signed(obs_a[hidx(t - j)][i*DW +: DW]) * $signed(obs_b[hidx(t - i)][j*DW +: DW]);
                  end
                  checks++;
                  if (got !== want) begin
                     failures++; $display("FAIL %s_C[%0d][%0d] got=%0d want=%0d", name, i, j, got, want);
                  end
               end
            end
         end
      end
      if (m_active) begin
         checks++; failures++; $display("FAIL %s_done_timeout busy=%0b want=0", name, busy);
      end
      tick();
      checks++;
      if (obs_v !== exp_v()) begin
         failures++; $display("FAIL %s_idle e=%0d got=%h want=%h", name, m_e, obs_v, exp_v());
      end
   endtask

   task automatic test_ignore();
      for (int c = 0; c < 16; c++) begin
         in_valid = (c < 3) || (c == 5) || (c == 6);
         in_last  = (c == 6);
         in_a = rnd_vec(); in_b = rnd_vec();
         start = (c == 3) || (c == 5) || (c == 6) || (c == 7);
         tick();
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL ignore e=%0d got=%h want=%h", m_e, obs_v, exp_v());
         end
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_flush_reset();
      for (int c = 0; c < 2 * N + 10; c++) begin
         start    = (c == 0);
         in_valid = (c == 2) || (c == 3);
         in_last  = (c == 3);
         in_a = rnd_vec(); in_b = rnd_vec();
         rst = (c == 7);
         tick();
         checks++;
         if (obs_v !== exp_v()) begin
            failures++; $display("FAIL flush_reset e=%0d got=%h want=%h", m_e, obs_v, exp_v());
         end
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_feed("skew", 3, 1, 0);
      test_feed("ident", 0, 4, 0);
      test_feed("signed", 2, 4, 40);
      test_feed("rand", 1, 6, 30);
      test_ignore();
      test_flush_reset();
      test_feed("after_rst", 1, 3, 20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
